// File: rtl/vend_change_payout_ctrl.sv
// vend_change_payout_ctrl
// Pays out a change amount as single coins from a 10-unit and a 5-unit hopper.
// Payout is greedy (tens first). After each eject pulse the controller waits for
// the hopper acknowledge before it decides on the next coin. It also tracks the
// coin inventory of both hoppers.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_amount       change request; accepted when req_ready is high
//   req_ready                  high only while idle
//   refill_valid/_ten/_five    inventory refill, applied only while idle (saturating)
//   hop_ten/hop_five           one-cycle eject pulses to the hoppers
//   hop_ack                    hopper confirms a coin left
//   busy                       high whenever a payout is in progress
//   done/err_short             one-cycle completion / abort pulses
//   residual                   amount still owed, held until the next accept
//   ten_count/five_count       current inventory
//   low_change                 either inventory below LOW_TH
module vend_change_payout_ctrl #(
  parameter int AMT_W     = 6,
  parameter int CNT_W     = 8,
  parameter int INIT_TEN  = 20,
  parameter int INIT_FIVE = 20,
  parameter int LOW_TH    = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill_valid,
  input  logic [CNT_W-1:0] refill_ten,
  input  logic [CNT_W-1:0] refill_five,
  output logic             hop_ten,
  output logic             hop_five,
  input  logic             hop_ack,
  output logic             busy,
  output logic             done,
  output logic             err_short,
  output logic [AMT_W-1:0] residual,
  output logic [CNT_W-1:0] ten_count,
  output logic [CNT_W-1:0] five_count,
  output logic             low_change
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEL    = 3'd1,
    S_PAY10  = 3'd2,
    S_WAIT10 = 3'd3,
    S_PAY5   = 3'd4,
    S_WAIT5  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // The pulse cycle counts as the first cycle of the window, so the fault is
  // raised exactly TIMEOUT cycles after the eject pulse.
  localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TIMEOUT - 2);
  localparam logic [TMO_W-1:0] TMO_ONE       = TMO_W'(1);
  localparam logic [AMT_W-1:0] AMT_TEN       = AMT_W'(10);
  localparam logic [AMT_W-1:0] AMT_FIVE      = AMT_W'(5);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOW       = CNT_W'(LOW_TH);
  localparam logic [CNT_W-1:0] CNT_INIT_TEN  = CNT_W'(INIT_TEN);
  localparam logic [CNT_W-1:0] CNT_INIT_FIVE = CNT_W'(INIT_FIVE);
  localparam logic             LOW_INIT      = (INIT_TEN < LOW_TH) || (INIT_FIVE < LOW_TH);

  // Saturating inventory addition.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [AMT_W-1:0] residual_r, residual_nxt_s;
  logic [CNT_W-1:0] ten_r, ten_nxt_s;
  logic [CNT_W-1:0] five_r, five_nxt_s;
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
  logic             hop_ten_r, hop_five_r, done_r, err_r;
  logic             busy_r, ready_r, low_r;

  // Next-state, residual, inventory and timeout computation.
  always_comb begin
    state_nxt_s    = state_r;
    residual_nxt_s = residual_r;
    ten_nxt_s      = ten_r;
    five_nxt_s     = five_r;
    tmo_nxt_s      = tmo_r;
    case (state_r)
      S_IDLE: begin
        // Refill lands in the same edge as an accept, so SEL sees the new counts.
        if (refill_valid) begin
          ten_nxt_s  = sat_add(ten_r, refill_ten);
          five_nxt_s = sat_add(five_r, refill_five);
        end else begin
          ten_nxt_s  = ten_r;
          five_nxt_s = five_r;
        end
        if (req_valid) begin
          residual_nxt_s = req_amount;
          state_nxt_s    = S_SEL;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SEL: begin
        if (residual_r == {AMT_W{1'b0}}) begin
          state_nxt_s = S_DONE;
        end else if ((residual_r >= AMT_TEN) && (ten_r != {CNT_W{1'b0}})) begin
          state_nxt_s = S_PAY10;
        end else if ((residual_r >= AMT_FIVE) && (five_r != {CNT_W{1'b0}})) begin
          state_nxt_s = S_PAY5;
        end else begin
          state_nxt_s = S_ERR;
        end
      end
      S_PAY10: begin
        tmo_nxt_s   = {TMO_W{1'b0}};
        state_nxt_s = S_WAIT10;
      end
      S_PAY5: begin
        tmo_nxt_s   = {TMO_W{1'b0}};
        state_nxt_s = S_WAIT5;
      end
      S_WAIT10: begin
        if (hop_ack) begin
          residual_nxt_s = residual_r - AMT_TEN;
          ten_nxt_s      = ten_r - CNT_ONE;
          state_nxt_s    = S_SEL;
        end else if (tmo_r == TMO_LAST) begin
          state_nxt_s = S_ERR;
        end else begin
          tmo_nxt_s = tmo_r + TMO_ONE;
        end
      end
      S_WAIT5: begin
        if (hop_ack) begin
          residual_nxt_s = residual_r - AMT_FIVE;
          five_nxt_s     = five_r - CNT_ONE;
          state_nxt_s    = S_SEL;
        end else if (tmo_r == TMO_LAST) begin
          state_nxt_s = S_ERR;
        end else begin
          tmo_nxt_s = tmo_r + TMO_ONE;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      S_ERR:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      residual_r <= {AMT_W{1'b0}};
      ten_r      <= CNT_INIT_TEN;
      five_r     <= CNT_INIT_FIVE;
      tmo_r      <= {TMO_W{1'b0}};
      hop_ten_r  <= 1'b0;
      hop_five_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b1;
      low_r      <= LOW_INIT;
    end else begin
      state_r    <= state_nxt_s;
      residual_r <= residual_nxt_s;
      ten_r      <= ten_nxt_s;
      five_r     <= five_nxt_s;
      tmo_r      <= tmo_nxt_s;
      hop_ten_r  <= (state_nxt_s == S_PAY10);
      hop_five_r <= (state_nxt_s == S_PAY5);
      done_r     <= (state_nxt_s == S_DONE);
      err_r      <= (state_nxt_s == S_ERR);
      busy_r     <= (state_nxt_s != S_IDLE);
      ready_r    <= (state_nxt_s == S_IDLE);
      low_r      <= (ten_nxt_s < CNT_LOW) || (five_nxt_s < CNT_LOW);
    end
  end

  assign req_ready  = ready_r;
  assign hop_ten    = hop_ten_r;
  assign hop_five   = hop_five_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err_short  = err_r;
  assign residual   = residual_r;
  assign ten_count  = ten_r;
  assign five_count = five_r;
  assign low_change = low_r;

endmodule

// File: tb/tb_vend_change_payout_ctrl.sv
// Self-checking bench for vend_change_payout_ctrl. Each test pushes the expected
// coin sequence into exp_q; the payout driver records observed eject pulses
// into obs_q, and the test compares the two queues plus final status.
module tb_vend_change_payout_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [5:0] req_amount;
  logic       req_ready;
  logic       refill_valid;
  logic [7:0] refill_ten;
  logic [7:0] refill_five;
  logic       hop_ten, hop_five, hop_ack;
  logic       busy, done, err_short;
  logic [5:0] residual;
  logic [7:0] ten_count, five_count;
  logic       low_change;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int obs_q[$];

  vend_change_payout_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .refill_valid(refill_valid), .refill_ten(refill_ten), .refill_five(refill_five),
    .hop_ten(hop_ten), .hop_five(hop_five), .hop_ack(hop_ack),
    .busy(busy), .done(done), .err_short(err_short), .residual(residual),
    .ten_count(ten_count), .five_count(five_count), .low_change(low_change)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_amount = 6'd0; refill_valid = 1'b0;
    refill_ten = 8'd0; refill_five = 8'd0; hop_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Presents one request and follows the payout. outcome: 1=done, 2=err, 0=no end.
  // Cycle indices count edges since the request was presented (accept edge = 1).
  task automatic run_payout(input logic [5:0] amt, input bit ack_en, input bit rf_same,
                            input logic [7:0] rf_ten, input logic [7:0] rf_five,
                            input bit rf_busy, output int outcome,
                            output int first_pulse, output int last_pulse, output int end_idx);
    bit ack_nxt = 1'b0;
    bit fin = 1'b0;
    outcome = 0; first_pulse = -1; last_pulse = -1; end_idx = -1;
    @(negedge clk);
    req_valid = 1'b1; req_amount = amt;
    refill_valid = rf_same; refill_ten = rf_ten; refill_five = rf_five;
    @(posedge clk); #1;
    req_valid = 1'b0; refill_valid = rf_busy;
    for (int idx = 1; idx <= 300 && !fin; idx++) begin
      hop_ack = ack_nxt;
      ack_nxt = 1'b0;
      if (hop_ten) begin
        obs_q.push_back(10);
        if (first_pulse < 0) first_pulse = idx;
        last_pulse = idx; ack_nxt = ack_en;
      end
      if (hop_five) begin
        obs_q.push_back(5);
        if (first_pulse < 0) first_pulse = idx;
        last_pulse = idx; ack_nxt = ack_en;
      end
      if (done) begin
        outcome = 1; end_idx = idx; fin = 1'b1;
      end else if (err_short) begin
        outcome = 2; end_idx = idx; fin = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    refill_valid = 1'b0; hop_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  // Empties the ten hopper (20 coins) with four payouts of 50.
  task automatic drain_tens();
    int oc, fp, lp, ei;
    for (int k = 0; k < 4; k++) run_payout(6'd50, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    obs_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL reset_hs: busy=%b ready=%b want 0/1", busy, req_ready); end
    total++; if (residual !== 6'd0) begin bad++; $display("FAIL reset_residual: got %0d want 0", residual); end
    total++; if (ten_count !== 8'd20 || five_count !== 8'd20) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 20/20", ten_count, five_count); end
    total++; if ({hop_ten, hop_five, done, err_short, low_change} !== 5'b0) begin bad++; $display("FAIL reset_pulses: got %b want 00000", {hop_ten, hop_five, done, err_short, low_change}); end
  endtask

  task automatic test_greedy_25();
    int oc, fp, lp, ei;
    apply_reset();
    exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(5);
    run_payout(6'd25, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL g25_npulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e, o; e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL g25_coin: got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (fp !== 2) begin bad++; $display("FAIL g25_latency: got %0d want 2", fp); end
    total++; if (oc !== 1 || residual !== 6'd0) begin bad++; $display("FAIL g25_done: outcome=%0d residual=%0d want 1/0", oc, residual); end
    total++; if (ten_count !== 8'd18 || five_count !== 8'd19) begin bad++; $display("FAIL g25_counts: got %0d/%0d want 18/19", ten_count, five_count); end
    total++; if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL g25_after: done=%b busy=%b ready=%b want 0/0/1", done, busy, req_ready); end
  endtask

  task automatic test_tens_empty();
    int oc, fp, lp, ei;
    apply_reset();
    drain_tens();
    total++; if (ten_count !== 8'd0 || low_change !== 1'b1) begin bad++; $display("FAIL te_drain: ten=%0d low=%b want 0/1", ten_count, low_change); end
    repeat (4) exp_q.push_back(5);
    run_payout(6'd20, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL te_npulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e, o; e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL te_coin: got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (oc !== 1 || five_count !== 8'd16) begin bad++; $display("FAIL te_done: outcome=%0d five=%0d want 1/16", oc, five_count); end
  endtask

  // Continues from test_tens_empty: ten=0, five=16.
  task automatic test_short();
    int oc, fp, lp, ei;
    run_payout(6'd60, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    run_payout(6'd15, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    obs_q.delete();
    total++; if (five_count !== 8'd1) begin bad++; $display("FAIL sh_setup: five=%0d want 1", five_count); end
    exp_q.push_back(5);
    run_payout(6'd15, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL sh_npulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e, o; e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL sh_coin: got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (oc !== 2 || residual !== 6'd10 || five_count !== 8'd0) begin bad++; $display("FAIL sh_err: outcome=%0d residual=%0d five=%0d want 2/10/0", oc, residual, five_count); end
    run_payout(6'd3, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (oc !== 2 || residual !== 6'd3 || obs_q.size() !== 0) begin bad++; $display("FAIL sh_odd: outcome=%0d residual=%0d pulses=%0d want 2/3/0", oc, residual, obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    int oc, fp, lp, ei;
    apply_reset();
    run_payout(6'd10, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL to_npulses: got %0d want 1", obs_q.size()); end
    obs_q.delete();
    total++; if (oc !== 2 || (ei - fp) !== 16) begin bad++; $display("FAIL to_timing: outcome=%0d delay=%0d want 2/16", oc, ei - fp); end
    total++; if (ten_count !== 8'd20 || residual !== 6'd10) begin bad++; $display("FAIL to_state: ten=%0d residual=%0d want 20/10", ten_count, residual); end
  endtask

  task automatic test_refill();
    int oc, fp, lp, ei;
    apply_reset();
    @(negedge clk);
    refill_valid = 1'b1; refill_ten = 8'd250; refill_five = 8'd0;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    total++; if (ten_count !== 8'd255 || five_count !== 8'd20) begin bad++; $display("FAIL rf_sat: got %0d/%0d want 255/20", ten_count, five_count); end
    run_payout(6'd25, 1'b1, 1'b0, 8'd100, 8'd100, 1'b1, oc, fp, lp, ei);
    obs_q.delete();
    total++; if (oc !== 1 || ten_count !== 8'd253 || five_count !== 8'd19) begin bad++; $display("FAIL rf_busy: outcome=%0d counts=%0d/%0d want 1/253/19", oc, ten_count, five_count); end
  endtask

  task automatic test_refill_same_cycle();
    int oc, fp, lp, ei;
    apply_reset();
    drain_tens();
    exp_q.push_back(10);
    run_payout(6'd10, 1'b1, 1'b1, 8'd1, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL same_npulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e, o; e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL same_coin: got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (oc !== 1 || ten_count !== 8'd0 || five_count !== 8'd20) begin bad++; $display("FAIL same_done: outcome=%0d counts=%0d/%0d want 1/0/20", oc, ten_count, five_count); end
  endtask

  task automatic test_reset_mid();
    int oc, fp, lp, ei;
    bit seen = 1'b0;
    apply_reset();
    @(negedge clk);
    req_valid = 1'b1; req_amount = 6'd30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (hop_ten) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rm_pulse: got %b want 1", seen); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || req_ready !== 1'b1 || residual !== 6'd0) begin bad++; $display("FAIL rm_state: busy=%b ready=%b residual=%0d want 0/1/0", busy, req_ready, residual); end
    total++; if (ten_count !== 8'd20 || five_count !== 8'd20 || hop_ten !== 1'b0) begin bad++; $display("FAIL rm_counts: %0d/%0d hop=%b want 20/20/0", ten_count, five_count, hop_ten); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5);
    run_payout(6'd5, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, oc, fp, lp, ei);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rm_npulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e, o; e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rm_coin: got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (oc !== 1 || five_count !== 8'd19) begin bad++; $display("FAIL rm_done: outcome=%0d five=%0d want 1/19", oc, five_count); end
  endtask

  initial begin
    test_reset();
    test_greedy_25();
    test_tens_empty();
    test_short();
    test_timeout();
    test_refill();
    test_refill_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
